// File: rtl/ad9500_pkg.sv
// rtl/ad9500_pkg.sv - shared types and default constants for the AD9500 delay-chip controller
package ad9500_pkg;

  // Controller sequence: load a code (SETUP/LATCH), sit ARMED, then fire/measure/clear.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    LATCH = 3'd2,
    ARMED = 3'd3,
    FIRE  = 3'd4,
    WAIT  = 3'd5,
    RST   = 3'd6,
    DONE  = 3'd7
  } state_t;

  localparam int SETUP_CYC_DEF   = 2;
  localparam int LE_CYC_DEF      = 2;
  localparam int TRIG_CYC_DEF    = 2;
  localparam int RST_CYC_DEF     = 3;
  localparam int TIMEOUT_CYC_DEF = 255;
  localparam int MEAS_W_DEF      = 12;

  // Measured TRIG-to-Q delay at the default counter width.
  typedef logic [MEAS_W_DEF-1:0] meas_t;

  // Width of the per-state phase timer; all phase lengths fit comfortably.
  localparam int TMR_W = 8;

endpackage

// File: rtl/ad9500_qsync.sv
// rtl/ad9500_qsync.sv - two-flop synchronizer and rising-edge detector for the chip Q pin
module ad9500_qsync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  // Shift the asynchronous pin through two stages, then keep one more sample for edge compare.
  always_comb begin
    s1_d   = d;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  // Synchronizer and edge registers; reset clears every stage so no false edge follows reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/ad9500_ctrl.sv
// rtl/ad9500_ctrl.sv - sequencer that loads, fires, times and clears one AD9500 delay chip
module ad9500_ctrl
  import ad9500_pkg::*;
#(
  parameter int SETUP_CYC   = SETUP_CYC_DEF,
  parameter int LE_CYC      = LE_CYC_DEF,
  parameter int TRIG_CYC    = TRIG_CYC_DEF,
  parameter int RST_CYC     = RST_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int MEAS_W      = MEAS_W_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cfg_valid,
  input  logic [7:0]        cfg_code,
  output logic              cfg_ready,
  input  logic              fire_req,
  output logic              fire_drop,
  output logic              armed,
  output logic              busy,
  output logic              done,
  output logic [MEAS_W-1:0] meas,
  output logic              timeout,
  output logic [7:0]        dly_d,
  output logic              dly_le,
  output logic              dly_trig,
  output logic              dly_reset,
  input  logic              dly_q
);

  localparam logic [TMR_W-1:0]  SETUP_LAST = TMR_W'(SETUP_CYC - 1);
  localparam logic [TMR_W-1:0]  LE_LAST    = TMR_W'(LE_CYC - 1);
  localparam logic [TMR_W-1:0]  TRIG_LAST  = TMR_W'(TRIG_CYC - 1);
  localparam logic [TMR_W-1:0]  RST_LAST   = TMR_W'(RST_CYC - 1);
  localparam logic [MEAS_W-1:0] TMO_CNT    = MEAS_W'(TIMEOUT_CYC);

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [MEAS_W-1:0]  cnt_q, cnt_d;
  logic               to_hit_q, to_hit_d;
  logic [7:0]         code_q, code_d;
  logic               le_q, le_d;
  logic               trig_q, trig_d;
  logic               crst_q, crst_d;
  logic               armed_q, armed_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [MEAS_W-1:0]  meas_q, meas_d;
  logic               timeout_q, timeout_d;

  logic q_rise;
  logic cfg_take;

  ad9500_qsync u_qsync (
    .clk  (CLK),
    .rst  (RESET),
    .d    (dly_q),
    .rise (q_rise)
  );

  // A fire request in ARMED takes priority, so the load offer is refused that cycle.
  assign cfg_ready = (state_q == IDLE) | ((state_q == ARMED) & ~fire_req);
  assign cfg_take  = cfg_valid & cfg_ready;
  assign fire_drop = fire_req & (state_q != ARMED);

  // Next-state, phase timer, delay counter and the registered-output values derived from state_d.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    cnt_d    = cnt_q;
    to_hit_d = to_hit_q;
    code_d   = code_q;

    case (state_q)
      IDLE: begin
        if (cfg_take) begin
          state_d = SETUP;
          tmr_d   = '0;
          code_d  = cfg_code;
        end
      end
      SETUP: begin
        if (tmr_q == SETUP_LAST) begin
          state_d = LATCH;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      LATCH: begin
        if (tmr_q == LE_LAST) begin
          state_d = ARMED;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ARMED: begin
        if (fire_req) begin
          state_d = FIRE;
          tmr_d   = '0;
          cnt_d   = '0;
        end else if (cfg_take) begin
          state_d = SETUP;
          tmr_d   = '0;
          code_d  = cfg_code;
        end
      end
      FIRE, WAIT: begin
        if (q_rise) begin
          state_d  = RST;
          tmr_d    = '0;
          to_hit_d = 1'b0;
        end else if (cnt_q == TMO_CNT) begin
          state_d  = RST;
          tmr_d    = '0;
          to_hit_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (state_q == FIRE) begin
            if (tmr_q == TRIG_LAST) begin
              state_d = WAIT;
              tmr_d   = '0;
            end else begin
              tmr_d = tmr_q + 1'b1;
            end
          end
        end
      end
      RST: begin
        if (tmr_q == RST_LAST) begin
          state_d = DONE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      DONE: begin
        state_d = ARMED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    le_d      = (state_d == LATCH);
    trig_d    = (state_d == FIRE);
    crst_d    = (state_d == RST);
    armed_d   = (state_d == ARMED);
    busy_d    = (state_d != IDLE) && (state_d != ARMED);
    done_d    = (state_d == DONE);
    meas_d    = (state_d == DONE) ? cnt_q : meas_q;
    timeout_d = (state_d == DONE) ? to_hit_q : timeout_q;
  end

  // State and output registers; reset drops the chip strobes immediately, even mid-cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      to_hit_q  <= 1'b0;
      code_q    <= '0;
      le_q      <= 1'b0;
      trig_q    <= 1'b0;
      crst_q    <= 1'b0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      meas_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      to_hit_q  <= to_hit_d;
      code_q    <= code_d;
      le_q      <= le_d;
      trig_q    <= trig_d;
      crst_q    <= crst_d;
      armed_q   <= armed_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      meas_q    <= meas_d;
      timeout_q <= timeout_d;
    end
  end

  assign dly_d     = code_q;
  assign dly_le    = le_q;
  assign dly_trig  = trig_q;
  assign dly_reset = crst_q;
  assign armed     = armed_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign meas      = meas_q;
  assign timeout   = timeout_q;

endmodule
